dmac_desc_fifo: RTL and testbench

Descriptor queue directly upstream of the DMAC master. The slave/register side pushes transfer descriptors (source address, destination address, word count). The master pops them with rd_en and samples source_addr/dest_addr/data_size and data_count one cycle later. The block provides 8-entry buffering, occupancy count, full/empty flags and registered ack/error status driven by an operation state machine.

---
 rtl/dmac_pkg.sv | 35 +++
 rtl/dmac_desc_fifo_if.sv | 41 ++++
 rtl/dmac_desc_regfile.sv | 37 +++
 rtl/dmac_desc_fifo.sv | 105 ++++++++++
 tb/tb_dmac_desc_fifo.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dmac_pkg.sv
// dmac_pkg
//   Shared definitions for the DMAC slice: descriptor geometry, FIFO
//   operation-state encodings and the DMAC master state encodings.
//   Imported by the descriptor FIFO, its interface and the bench.
package dmac_pkg;

   localparam int AW     = 16;        // address / size field width
   localparam int DESC_W = 3 * AW;    // {src, dst, size}
   localparam int DEPTH  = 8;         // descriptor entries
   localparam int PTR_W  = 3;         // log2(DEPTH)
   localparam int CNT_W  = 4;         // occupancy 0..DEPTH

   // Descriptor FIFO operation states (3-bit, legacy-compatible encoding)
   localparam logic [2:0] FS_INIT     = 3'd0;
   localparam logic [2:0] FS_NO_OP    = 3'd1;
   localparam logic [2:0] FS_WRITE    = 3'd2;
   localparam logic [2:0] FS_WR_ERROR = 3'd3;
   localparam logic [2:0] FS_READ     = 3'd4;
   localparam logic [2:0] FS_RD_ERROR = 3'd5;
   localparam logic [2:0] FS_RW_BOTH  = 3'd6;

   // DMAC master states, shared so the master and bench agree on encoding
   localparam logic [2:0] MS_IDLE     = 3'd0;
   localparam logic [2:0] MS_FIFO_POP = 3'd1;
   localparam logic [2:0] MS_RD_SRC   = 3'd2;
   localparam logic [2:0] MS_WR_DST   = 3'd3;
   localparam logic [2:0] MS_DONE     = 3'd4;

   typedef struct packed {
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [AW-1:0] size;
   } desc_t;

endpackage

// File: rtl/dmac_desc_fifo_if.sv
// dmac_desc_fifo_if
//   Bundles the descriptor FIFO push/pop handshake, data and status.
//   slave  : the FIFO itself (takes requests, drives data and status)
//   master : the agent pushing/popping descriptors
//   state is the FIFO operation state, exposed for observation.
interface dmac_desc_fifo_if
   import dmac_pkg::*;
#(
   parameter int AW    = dmac_pkg::AW,
   parameter int CNT_W = dmac_pkg::CNT_W
);
   logic             clear;
   logic             wr_en;
   logic [AW-1:0]    din_src;
   logic [AW-1:0]    din_dst;
   logic [AW-1:0]    din_size;
   logic             rd_en;
   logic [AW-1:0]    source_addr;
   logic [AW-1:0]    dest_addr;
   logic [AW-1:0]    data_size;
   logic [CNT_W-1:0] data_count;
   logic             full;
   logic             empty;
   logic             wr_ack;
   logic             wr_err;
   logic             rd_ack;
   logic             rd_err;
   logic [2:0]       state;

   modport slave (
      input  clear, wr_en, din_src, din_dst, din_size, rd_en,
      output source_addr, dest_addr, data_size, data_count,
             full, empty, wr_ack, wr_err, rd_ack, rd_err, state
   );

   modport master (
      output clear, wr_en, din_src, din_dst, din_size, rd_en,
      input  source_addr, dest_addr, data_size, data_count,
             full, empty, wr_ack, wr_err, rd_ack, rd_err, state
   );
endinterface

// File: rtl/dmac_desc_regfile.sv
// dmac_desc_regfile
//   DEPTH x W descriptor storage. Synchronous write port; synchronous read
//   straight into the output register, which holds until the next read.
//   clk, reset : clock, synchronous active-high reset (output reg only)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
module dmac_desc_regfile
   import dmac_pkg::*;
#(
   parameter int DEPTH = dmac_pkg::DEPTH,
   parameter int PTR_W = dmac_pkg::PTR_W,
   parameter int W     = dmac_pkg::DESC_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [W-1:0]     wdata,
   input  logic             re,
   input  logic [PTR_W-1:0] raddr,
   output logic [W-1:0]     rdata
);
   logic [W-1:0] mem [DEPTH];

   // NOTE: storage is deliberately not reset; an entry is only read after
   // it has been written, so a reset here would only cost flops.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // When full, a same-edge write to raddr lands after this read samples
   // the old entry, so the oldest descriptor is returned.
   always_ff @(posedge clk) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/dmac_desc_fifo.sv
// dmac_desc_fifo
//   Descriptor queue feeding the DMAC master. Pushes {src, dst, size},
//   pops into registered outputs one cycle after rd_en, tracks occupancy
//   and reports registered ack/error status from an operation FSM.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset (priority over clear)
//   bus   : dmac_desc_fifo_if.slave (requests, descriptor data, status)
module dmac_desc_fifo
   import dmac_pkg::*;
#(
   parameter int DEPTH = dmac_pkg::DEPTH,
   parameter int PTR_W = dmac_pkg::PTR_W,
   parameter int AW    = dmac_pkg::AW
) (
   input  logic            clk,
   input  logic            reset,
   dmac_desc_fifo_if.slave bus
);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [2:0]       state_nx;
   logic             push;
   logic             pop;
   logic             run;

   assign bus.data_count = count;
   assign bus.full       = (count == FULL_CNT);
   assign bus.empty      = (count == '0);

   // A push while full is allowed only alongside a pop, which frees the slot.
   assign push = bus.wr_en && (!bus.full || bus.rd_en);
   // No bypass: a pop at empty is rejected even with a concurrent push.
   assign pop  = bus.rd_en && !bus.empty;
   assign run  = !reset && !bus.clear;

   // NOTE: every branch starts from a default so no latch is inferred.
   always_comb begin
      state_nx = FS_NO_OP;
      if (push && pop)  state_nx = FS_RW_BOTH;
      else if (push)    state_nx = FS_WRITE;
      else if (pop)     state_nx = FS_READ;
      else if (bus.wr_en) state_nx = FS_WR_ERROR;
      else if (bus.rd_en) state_nx = FS_RD_ERROR;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         bus.state  <= FS_INIT;
         bus.wr_ack <= 1'b0;
         bus.wr_err <= 1'b0;
         bus.rd_ack <= 1'b0;
         bus.rd_err <= 1'b0;
      end else if (bus.clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         bus.state  <= FS_NO_OP;
         bus.wr_ack <= 1'b0;
         bus.wr_err <= 1'b0;
         bus.rd_ack <= 1'b0;
         bus.rd_err <= 1'b0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by natural overflow.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         bus.state  <= state_nx;
         bus.wr_ack <= push;
         bus.wr_err <= bus.wr_en && !push;
         bus.rd_ack <= pop;
         bus.rd_err <= bus.rd_en && !pop;
      end
   end

   logic [3*AW-1:0] desc_q;

   dmac_desc_regfile #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .W     (3*AW)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (run && push),
      .waddr (wr_ptr),
      .wdata ({bus.din_src, bus.din_dst, bus.din_size}),
      .re    (run && pop),
      .raddr (rd_ptr),
      .rdata (desc_q)
   );

   assign {bus.source_addr, bus.dest_addr, bus.data_size} = desc_q;
endmodule

// File: tb/tb_dmac_desc_fifo.sv
// tb_dmac_desc_fifo
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a queue-based reference model of the descriptor FIFO.
module tb_dmac_desc_fifo;
   import dmac_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmac_desc_fifo_if bus ();

   dmac_desc_fifo u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model
   logic [47:0] q[$];
   logic [47:0] m_out;
   logic        m_wr_ack, m_wr_err, m_rd_ack, m_rd_err;
   logic [2:0]  m_state;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit clr, input bit wr, input bit rd,
                             input logic [47:0] d);
      int  n;
      bit  pa, pp;
      if (rst) begin
         q.delete();
         m_out = '0;
         {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err} = '0;
         m_state = FS_INIT;
      end else if (clr) begin
         q.delete();
         {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err} = '0;
         m_state = FS_NO_OP;
      end else begin
         n  = q.size();
         pa = wr && (n < DEPTH || rd);
         pp = rd && (n > 0);
         if (pp) m_out = q.pop_front();   // oldest leaves before any overwrite
         if (pa) q.push_back(d);
         m_wr_ack = pa;  m_wr_err = wr && !pa;
         m_rd_ack = pp;  m_rd_err = rd && !pp;
         if (!wr && !rd)       m_state = FS_NO_OP;
         else if (pa && pp)    m_state = FS_RW_BOTH;
         else if (pa)          m_state = FS_WRITE;
         else if (pp)          m_state = FS_READ;
         else if (wr)          m_state = FS_WR_ERROR;
         else                  m_state = FS_RD_ERROR;
      end
   endtask

   task automatic check_all();
      check("data_count", 48'(bus.data_count), 48'(q.size()));
      check("full",       48'(bus.full),       48'(q.size() == DEPTH));
      check("empty",      48'(bus.empty),      48'(q.size() == 0));
      check("desc_out",   {bus.source_addr, bus.dest_addr, bus.data_size}, m_out);
      check("wr_ack",     48'(bus.wr_ack),     48'(m_wr_ack));
      check("wr_err",     48'(bus.wr_err),     48'(m_wr_err));
      check("rd_ack",     48'(bus.rd_ack),     48'(m_rd_ack));
      check("rd_err",     48'(bus.rd_err),     48'(m_rd_err));
      check("state",      48'(bus.state),      48'(m_state));
   endtask

   task automatic cycle(input bit rst, input bit clr, input bit wr, input bit rd,
                        input logic [15:0] s, input logic [15:0] d, input logic [15:0] z);
      reset        = rst;
      bus.clear    = clr;
      bus.wr_en    = wr;
      bus.rd_en    = rd;
      bus.din_src  = s;
      bus.din_dst  = d;
      bus.din_size = z;
      @(posedge clk);
      model_step(rst, clr, wr, rd, {s, d, z});
      #1;
      check_all();
   endtask

   task automatic push(input logic [15:0] s);
      cycle(0, 0, 1, 0, s, s ^ 16'h5a5a, s + 16'd3);
   endtask
   task automatic pop();
      cycle(0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
   endtask
   task automatic idle();
      cycle(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
   endtask

   initial begin
      reset = 1'b1;
      bus.clear = 0; bus.wr_en = 0; bus.rd_en = 0;
      bus.din_src = 0; bus.din_dst = 0; bus.din_size = 0;

      // reset then idle
      cycle(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      check("rst_state", 48'(bus.state), 48'(FS_INIT));
      idle();
      check("idle_src", 48'(bus.source_addr), 48'h0);

      // single descriptor round trip
      cycle(0, 0, 1, 0, 16'h0100, 16'h0200, 16'h0004);
      idle();
      pop();
      check("pop1_src",  48'(bus.source_addr), 48'h0100);
      check("pop1_dst",  48'(bus.dest_addr),   48'h0200);
      check("pop1_size", 48'(bus.data_size),   48'h0004);
      check("pop1_ack",  48'(bus.rd_ack),      48'h1);

      // fill, overflow, drain, underflow
      for (int i = 0; i < 8; i++) push(16'h0010 + 16'(i));
      push(16'h00ff);
      check("ovf_err",   48'(bus.wr_err),     48'h1);
      check("ovf_count", 48'(bus.data_count), 48'h8);
      for (int i = 0; i < 8; i++) begin
         pop();
         check("drain_src", 48'(bus.source_addr), 48'h10 + 48'(i));
      end
      pop();
      check("udf_err", 48'(bus.rd_err),      48'h1);
      check("udf_src", 48'(bus.source_addr), 48'h17);

      // wrap-around across pointer 7 -> 0
      for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i));
      for (int i = 0; i < 5; i++) pop();
      for (int i = 0; i < 6; i++) push(16'h0200 + 16'(i));
      for (int i = 0; i < 6; i++) begin
         pop();
         check("wrap_src", 48'(bus.source_addr), 48'h200 + 48'(i));
      end
      check("wrap_count", 48'(bus.data_count), 48'h0);

      // simultaneous at full
      for (int i = 0; i < 8; i++) push(16'h0300 + 16'(i));
      cycle(0, 0, 1, 1, 16'h0aaa, 16'h0bbb, 16'h0ccc);
      check("rw_full_src",   48'(bus.source_addr), 48'h300);
      check("rw_full_count", 48'(bus.data_count),  48'h8);
      check("rw_full_acks",  48'({bus.wr_ack, bus.rd_ack}), 48'h3);
      for (int i = 0; i < 8; i++) pop();

      // simultaneous at empty
      cycle(0, 0, 1, 1, 16'h0777, 16'h0888, 16'h0999);
      check("rw_empty_count", 48'(bus.data_count), 48'h1);
      check("rw_empty_flags", 48'({bus.wr_ack, bus.rd_err}), 48'h3);
      pop();

      // clear at count 3, then reset in the middle of a push
      for (int i = 0; i < 3; i++) push(16'h0400 + 16'(i));
      cycle(0, 1, 1, 0, 16'h0499, 16'h0, 16'h0);
      check("clr_empty", 48'(bus.empty), 48'h1);
      push(16'h0500);
      cycle(1, 0, 1, 0, 16'h0599, 16'h0, 16'h0);
      check("rst_mid_state", 48'(bus.state),      48'(FS_INIT));
      check("rst_mid_count", 48'(bus.data_count), 48'h0);
      idle();

      // randomized traffic in phases with different push/pop bias
      for (int ph = 0; ph < 6; ph++) begin
         int wr_pct, rd_pct;
         wr_pct = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
         rd_pct = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 55;
         for (int c = 0; c < 250; c++) begin
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 99) < wr_pct,
                  $urandom_range(0, 99) < rd_pct,
                  16'($urandom), 16'($urandom), 16'($urandom));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
